// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the weight memory loader and the sequential weight
// reader: FSM state encoding and the address-width helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package nn_pkg;

  // Loader/reader frame states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Address width for a memory of the given depth; never below 1 bit.
  function automatic int addr_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/weight_loader_if.sv
// -----------------------------------------------------------------------------
// weight_loader_if
// Groups the weight stream handshake, the memory write port and the frame
// status of the weight loader.
//   slave  : the loader's view (stream in, write port/status out)
//   master : the host/DMA and memory view (stream out, write port/status in)
// Signals:
//   start, din, din_valid, din_last  host -> loader
//   din_ready                        loader -> host
//   wen, wadd, win                   loader -> weight memory write port
//   busy, done, err, checksum        loader -> host status
// -----------------------------------------------------------------------------
interface weight_loader_if #(
  parameter int ADDR      = 256,
  parameter int DIN_WIDTH = 16
);
  localparam int AW = nn_pkg::addr_width(ADDR);

  logic                 start;
  logic [DIN_WIDTH-1:0] din;
  logic                 din_valid;
  logic                 din_last;
  logic                 din_ready;
  logic                 wen;
  logic [AW-1:0]        wadd;
  logic [DIN_WIDTH-1:0] win;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [DIN_WIDTH-1:0] checksum;

  modport slave (
    input  start, din, din_valid, din_last,
    output din_ready, wen, wadd, win, busy, done, err, checksum
  );

  modport master (
    output start, din, din_valid, din_last,
    input  din_ready, wen, wadd, win, busy, done, err, checksum
  );

endinterface

// File: rtl/weight_loader_fsm.sv
// -----------------------------------------------------------------------------
// weight_loader_fsm
// Frame controller of the weight loader: owns the frame state, the write
// address counter and the sticky length-error flag, and decides which
// accepted words are written to memory.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         frame start pulse (honoured in IDLE/DONE only)
//   valid_i, last_i stream word valid / final-word marker
//   state_o         registered frame state
//   cnt_o           address of the next word to write
//   write_o         an accepted word is to be written this cycle
//   load_start_o    a new frame is being armed this cycle
//   err_o           length mismatch in the current/last frame
// -----------------------------------------------------------------------------
module weight_loader_fsm
  import nn_pkg::*;
#(
  parameter int ADDR = 256,
  parameter int AW   = addr_width(ADDR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          valid_i,
  input  logic          last_i,
  output state_e        state_o,
  output logic [AW-1:0] cnt_o,
  output logic          write_o,
  output logic          load_start_o,
  output logic          err_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(ADDR - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          accept_s;

  // Next-state, counter and error decisions for the frame controller.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    load_start_o = 1'b0;
    // din_ready is decoded from state alone, so accept only depends on valid.
    accept_s     = valid_i && ((state_q == ST_LOAD) || (state_q == ST_DRAIN));
    write_o      = accept_s && (state_q == ST_LOAD);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d      = ST_LOAD;
          cnt_d        = '0;
          err_d        = 1'b0;
          load_start_o = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          if (last_i) begin
            state_d = ST_DONE;
            err_d   = (cnt_q != LAST_ADDR);
          end else if (cnt_q == LAST_ADDR) begin
            // Memory full but frame continues: swallow the rest. The
            // counter stays at the top address and never wraps.
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (accept_s && last_i) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame state, counter and error registers; reset overrides start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state_o = state_q;
  assign cnt_o   = cnt_q;
  assign err_o   = err_q;

endmodule

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
// Accepts a framed stream of weight words and writes them to consecutive
// weight memory addresses starting at 0, flagging short and long frames.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  weight_loader_if.slave: stream handshake (start/din/din_valid/
//        din_last/din_ready), memory write port (wen/wadd/win, registered,
//        1-cycle latency) and status (busy/done/err/checksum)
// Configuration macro: WEIGHT_LOADER_CHECKSUM_EN -- when defined, checksum
// is the running sum (mod 2^DIN_WIDTH) of the words written in the frame;
// otherwise checksum is tied to 0.
// -----------------------------------------------------------------------------
module weight_loader
  import nn_pkg::*;
#(
  parameter int ADDR      = 256,
  parameter int DIN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  weight_loader_if.slave       bus
);

  localparam int AW = addr_width(ADDR);

  state_e               state_s;
  logic [AW-1:0]        cnt_s;
  logic                 write_s;
  logic                 load_start_s;
  logic                 err_s;

  logic                 wen_q;
  logic [AW-1:0]        wadd_q;
  logic [DIN_WIDTH-1:0] win_q;

  weight_loader_fsm #(
    .ADDR (ADDR),
    .AW   (AW)
  ) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .start_i      (bus.start),
    .valid_i      (bus.din_valid),
    .last_i       (bus.din_last),
    .state_o      (state_s),
    .cnt_o        (cnt_s),
    .write_o      (write_s),
    .load_start_o (load_start_s),
    .err_o        (err_s)
  );

  // Write port register: a word accepted in LOAD reaches memory next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q  <= 1'b0;
      wadd_q <= '0;
      win_q  <= '0;
    end else begin
      wen_q <= write_s;
      if (write_s) begin
        wadd_q <= cnt_s;
        win_q  <= bus.din;
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [DIN_WIDTH-1:0] sum_q, sum_d;

  // Checksum next value; summed at accept so it lands together with wen.
  always_comb begin
    sum_d = sum_q;
    if (load_start_s) begin
      sum_d = '0;
    end else if (write_s) begin
      sum_d = sum_q + bus.din;
    end else begin
      sum_d = sum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign bus.checksum = sum_q;
`else
  assign bus.checksum = '0;
`endif

  assign bus.wen       = wen_q;
  assign bus.wadd      = wadd_q;
  assign bus.win       = win_q;
  assign bus.din_ready = (state_s == ST_LOAD) || (state_s == ST_DRAIN);
  assign bus.busy      = (state_s == ST_LOAD) || (state_s == ST_DRAIN);
  assign bus.done      = (state_s == ST_DONE);
  assign bus.err       = err_s;

endmodule

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
// Directed bench for weight_loader with ADDR=4, DIN_WIDTH=16. Expected write
// addresses/data, status and checksums are hand-computed per vector.
// -----------------------------------------------------------------------------
module tb_weight_loader;

  localparam int ADDR = 4;
  localparam int DW   = 16;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total_cnt;
  int   bad_cnt;

  weight_loader_if #(.ADDR(ADDR), .DIN_WIDTH(DW)) bus ();

  weight_loader #(.ADDR(ADDR), .DIN_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected checksum for a given sum of written words.
  function automatic logic [31:0] exp_cs(input int v);
    return CS_EN ? 32'(v % 65536) : 32'd0;
  endfunction

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Offer one word, wait (bounded) for its accept, then check the write port
  // in the cycle right after the accept.
  task automatic send(input logic [15:0] d, input logic last, input logic exp_wen,
                      input logic [1:0] exp_addr);
    logic rdy;
    int   n;
    n = 0;
    bus.din       = d;
    bus.din_last  = last;
    bus.din_valid = 1'b1;
    do begin
      rdy = bus.din_ready;
      step();
      n++;
    end while (!rdy && n < 8);
    if (!rdy) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      check("wen", 32'(bus.wen), 32'(exp_wen));
      if (exp_wen) begin
        check("wadd", 32'(bus.wadd), 32'(exp_addr));
        check("win", 32'(bus.win), 32'(d));
      end
    end
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  initial begin
    total_cnt     = 0;
    bad_cnt       = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.din       = 16'd0;
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;

    // Reset state
    step(); step(); step();
    check("rst_ready", 32'(bus.din_ready), 32'd0);
    check("rst_wen", 32'(bus.wen), 32'd0);
    check("rst_wadd", 32'(bus.wadd), 32'd0);
    check("rst_win", 32'(bus.win), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_cs", 32'(bus.checksum), 32'd0);
    rst = 1'b0;
    step();

    // Nominal frame, continuous valid: 1,2,3,4
    pulse_start();
    check("f1_busy", 32'(bus.busy), 32'd1);
    check("f1_ready", 32'(bus.din_ready), 32'd1);
    send(16'd1, 1'b0, 1'b1, 2'd0);
    send(16'd2, 1'b0, 1'b1, 2'd1);
    send(16'd3, 1'b0, 1'b1, 2'd2);
    send(16'd4, 1'b1, 1'b1, 2'd3);
    check("f1_done", 32'(bus.done), 32'd1);
    check("f1_busy_end", 32'(bus.busy), 32'd0);
    check("f1_err", 32'(bus.err), 32'd0);
    check("f1_cs", 32'(bus.checksum), exp_cs(10));
    step();
    check("f1_wen_off", 32'(bus.wen), 32'd0);
    check("f1_ready_off", 32'(bus.din_ready), 32'd0);

    // Frame with a gap after every word: 5,6,7,8
    pulse_start();
    check("f2_done_clr", 32'(bus.done), 32'd0);
    send(16'd5, 1'b0, 1'b1, 2'd0);
    step();
    check("f2_gap0", 32'(bus.wen), 32'd0);
    send(16'd6, 1'b0, 1'b1, 2'd1);
    step();
    check("f2_gap1", 32'(bus.wen), 32'd0);
    send(16'd7, 1'b0, 1'b1, 2'd2);
    step();
    check("f2_gap2", 32'(bus.wen), 32'd0);
    check("f2_busy_gap", 32'(bus.busy), 32'd1);
    send(16'd8, 1'b1, 1'b1, 2'd3);
    check("f2_done", 32'(bus.done), 32'd1);
    check("f2_err", 32'(bus.err), 32'd0);
    check("f2_cs", 32'(bus.checksum), exp_cs(26));
    step();
    check("f2_wen_off", 32'(bus.wen), 32'd0);

    // Short frame: last on the 3rd word
    pulse_start();
    send(16'd1, 1'b0, 1'b1, 2'd0);
    send(16'd2, 1'b0, 1'b1, 2'd1);
    send(16'd3, 1'b1, 1'b1, 2'd2);
    check("f3_done", 32'(bus.done), 32'd1);
    check("f3_err", 32'(bus.err), 32'd1);
    check("f3_cs", 32'(bus.checksum), exp_cs(6));
    step();
    check("f3_err_sticky", 32'(bus.err), 32'd1);
    pulse_start();
    check("f4_err_clr", 32'(bus.err), 32'd0);
    check("f4_done_clr", 32'(bus.done), 32'd0);
    check("f4_cs_clr", 32'(bus.checksum), 32'd0);

    // Long frame: 6 words, only the first 4 written
    send(16'd10, 1'b0, 1'b1, 2'd0);
    send(16'd20, 1'b0, 1'b1, 2'd1);
    send(16'd30, 1'b0, 1'b1, 2'd2);
    send(16'd40, 1'b0, 1'b1, 2'd3);
    check("f4_drain_busy", 32'(bus.busy), 32'd1);
    check("f4_drain_ready", 32'(bus.din_ready), 32'd1);
    check("f4_drain_done", 32'(bus.done), 32'd0);
    send(16'd50, 1'b0, 1'b0, 2'd0);
    send(16'd60, 1'b1, 1'b0, 2'd0);
    check("f4_done", 32'(bus.done), 32'd1);
    check("f4_err", 32'(bus.err), 32'd1);
    check("f4_cs", 32'(bus.checksum), exp_cs(100));

    // Reset mid-frame after the 2nd accept, with start in the reset cycle
    pulse_start();
    send(16'd1, 1'b0, 1'b1, 2'd0);
    send(16'd2, 1'b0, 1'b1, 2'd1);
    rst       = 1'b1;
    bus.start = 1'b1;
    step();
    check("mr_wen", 32'(bus.wen), 32'd0);
    check("mr_wadd", 32'(bus.wadd), 32'd0);
    check("mr_win", 32'(bus.win), 32'd0);
    check("mr_busy", 32'(bus.busy), 32'd0);
    check("mr_ready", 32'(bus.din_ready), 32'd0);
    check("mr_done", 32'(bus.done), 32'd0);
    check("mr_cs", 32'(bus.checksum), 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    step();
    check("mr_idle", 32'(bus.busy), 32'd0);

    // New frame from address 0, start pulsed mid-frame is ignored
    pulse_start();
    send(16'd7, 1'b0, 1'b1, 2'd0);
    send(16'd9, 1'b0, 1'b1, 2'd1);
    pulse_start();
    check("ms_busy", 32'(bus.busy), 32'd1);
    check("ms_wen", 32'(bus.wen), 32'd0);
    check("ms_cs", 32'(bus.checksum), exp_cs(16));
    send(16'd11, 1'b0, 1'b1, 2'd2);
    send(16'd13, 1'b1, 1'b1, 2'd3);
    check("ms_done", 32'(bus.done), 32'd1);
    check("ms_err", 32'(bus.err), 32'd0);
    check("ms_cs_end", 32'(bus.checksum), exp_cs(40));
    step();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
# weight_loader

Write-side companion to the sequential weight reader. It accepts a stream of weight words over a valid/ready handshake and writes them into consecutive addresses of the weight memory write port, starting at address 0. The number of words is checked against `ADDR`, and the block flags an error when a frame is too short or too long. It sits between the host/DMA weight stream and the `wen/wadd/win` inputs of the weight memory, which are otherwise tied off in pretrained builds.

## Interface
Parameters:
- `ADDR`, 256: number of weights per frame (memory depth).
- `DIN_WIDTH`, 16: weight word width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; arms a new load frame.
- `din`  in  DIN_WIDTH  weight word.
- `din_valid`  in  1  `din` is valid.
- `din_last`  in  1  marks the final word of the frame; qualified by `din_valid`.
- `din_ready`  out  1  block accepts a word this cycle.
- `wen`  out  1  memory write enable.
- `wadd`  out  $clog2(ADDR)  memory write address.
- `win`  out  DIN_WIDTH  memory write data.
- `busy`  out  1  frame in progress (LOAD or DRAIN).
- `done`  out  1  frame finished; held until the next `start`.
- `err`  out  1  length mismatch in the last frame; sticky until the next `start`.
- `checksum`  out  DIN_WIDTH  sum of written words (see Configuration).

## Operation
- FSM states:
  - IDLE → LOAD on `start`. The counter clears, `done`, `err` and `checksum` clear.
  - LOAD: accept when `din_valid & din_ready`.
    - Each accepted word writes `din` at address = counter, then counter increments.
    - Last-word check:
      - `din_last` on counter = ADDR-1 → DONE, `err`=0.
      - `din_last` on counter < ADDR-1 → DONE, `err`=1 (short frame). Words already written stay in memory.
      - Counter = ADDR-1 accepted without `din_last` → DRAIN (long frame).
  - DRAIN: `din_ready`=1. Words are accepted and discarded, with no `wen`. Accepting `din_last` → DONE, `err`=1.
  - DONE: `done`=1, `din_ready`=0. `start` → LOAD.
- `din_ready` = state is LOAD or DRAIN. It is decoded from registered state, with no combinational path from `din_valid`.
- `start` is ignored in LOAD and DRAIN. `start` in the same cycle as `rst` is ignored.
- The counter never wraps: it is at most ADDR-1, and no write goes beyond ADDR-1.
- `busy` = state is LOAD or DRAIN.

## Timing
- Reset values: state IDLE, counter 0, and `din_ready`, `wen`, `wadd`, `win`, `busy`, `done`, `err`, `checksum` all 0.
- Write latency is 1 cycle. `wen`, `wadd` and `win` are registered: a word accepted in cycle n appears at the memory port in cycle n+1, with `wen` high for exactly 1 cycle.
- Back-to-back accepts give back-to-back writes, with throughput of 1 word/cycle.
- `din_valid` low in LOAD: no write, state held.
- `done` and `busy` update in the cycle after the last accept, together with the final `wen`.
- `rst` mid-frame: return to IDLE the next cycle with `wen`=0. A write pending in the output register is dropped. Partial memory contents are undefined.

## Configuration
- `WEIGHT_LOADER_CHECKSUM_EN`:
  - Defined: `checksum` accumulates every written word (not DRAIN words) modulo 2^DIN_WIDTH. It is registered, updates with `wen`, clears on `start`, and is valid when `done`=1.
  - Undefined: `checksum` is constant 0 and no adder is synthesized.

## Structure
- Shared package (`nn_pkg`): FSM state encoding (IDLE, LOAD, DRAIN, DONE) and the address-width helper, `$clog2(ADDR)`, reused by the reader.
- One sub-module, `weight_loader_fsm`: owns state and counter, and produces accept/last-check decisions. The top registers the write port and the checksum.
- The memory itself stays outside the block; the top level wires `wadd/win/wen` to the Weight_mem write port.

## Test plan
- ADDR=4, start, then words 1,2,3,4 with `din_last` on 4, `din_valid` continuous → writes (0,1),(1,2),(2,3),(3,4) in consecutive cycles. `done`=1, `err`=0, `checksum`=10 (with _EN).
- ADDR=4, gaps in `din_valid` (valid every other cycle) → same 4 writes, each 1 cycle after its accept, with no extra `wen`.
- ADDR=4, `din_last` on the 3rd word → 3 writes, `done`=1, `err`=1. A subsequent `start` clears `err` and `done`.
- ADDR=4, 6 words with `din_last` on the 6th → 4 writes, words 5 and 6 consumed without `wen`, `err`=1, `checksum` counts only the first 4.
- `rst` asserted after the 2nd accept → next cycle all outputs 0, state IDLE. A new frame then writes from address 0.
- `start` pulsed during LOAD → ignored, with counter and `checksum` unchanged. Without `WEIGHT_LOADER_CHECKSUM_EN`, `checksum` stays 0 in all cases.
